decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have RST, input, 1 bit: asynchronous, active-low reset.
REQ-002 SHALL have CLK_DC, input, 1 bit: decode clock; all state changes on its rising edge.
REQ-003 SHALL have INSTR, input, 32 bits: fetched RV32I instruction word.
REQ-004 SHALL have IN_VALID, input, 1 bit: INSTR valid this cycle.
REQ-005 SHALL have IN_READY, output, 1 bit: combinational, 1 when state is IDLE.
REQ-006 SHALL have WB_DONE, input, 1 bit, and WB_RD, input, 5 bits: writeback retire pulse and its destination register.
REQ-007 SHALL have A1, A2 and A3, outputs, 5 bits each: register-file addresses rs1, rs2 and rd.
REQ-008 SHALL have WE, output, 1 bit: register write enable for the decoded instruction.
REQ-009 SHALL have IMM, output, 32 bits: sign-extended immediate.
REQ-010 SHALL have OPCODE, output, 7 bits, and FUNCT3, output, 3 bits: passed-through fields.
REQ-011 SHALL have FUNCT7B5, output, 1 bit: INSTR[30], the ALU sub/sra selector.
REQ-012 SHALL have OUT_VALID, output, 1 bit: outputs hold a newly issued instruction; one-cycle pulse per issue.
REQ-013 SHALL have ILLEGAL, output, 1 bit: the issued instruction is unrecognised.
REQ-014 SHALL have ILL_CNT, output, 8 bits: saturating count of illegal issues.

Function
REQ-015 States SHALL be IDLE and HOLD; an accept SHALL occur when IN_VALID=1 and state is IDLE.
REQ-016 Accept with no hazard: on the same edge, all outputs SHALL be registered and OUT_VALID SHALL be 1; latency is one CLK_DC edge.
REQ-017 Accept with a hazard: INSTR SHALL be captured into a hold register, the state SHALL go to HOLD, and OUT_VALID SHALL be 0.
REQ-018 In HOLD, the held word SHALL be re-checked every cycle, issued on the first hazard-free edge, and the state SHALL return to IDLE; INSTR SHALL be ignored while in HOLD.
REQ-019 With no issue, OUT_VALID SHALL be 0 and all other outputs SHALL hold their previous values.
REQ-020 A hazard SHALL exist when pending[rs1] is set or pending[rs2] is set; pending[0] SHALL always read 0.
REQ-021 For R, S and B formats both rs1 and rs2 SHALL be checked; for I format only rs1; for U and J formats neither.
REQ-022 On issue with WE=1 and rd≠0, pending[rd] SHALL be set.
REQ-023 WB_DONE=1 SHALL clear pending[WB_RD].
REQ-024 A clear in the same cycle SHALL be visible to that cycle's hazard check (bypass).
REQ-025 A simultaneous set and clear of the same register SHALL leave it set.
REQ-026 IMM formats SHALL follow RV32I:
- I: INSTR[31:20]
- S: {INSTR[31:25], INSTR[11:7]}
- B: {INSTR[31], INSTR[7], INSTR[30:25], INSTR[11:8], 0}
- U: {INSTR[31:12], 12'h0}
- J: {INSTR[31], INSTR[19:12], INSTR[20], INSTR[30:21], 0}
- All SHALL be sign-extended from INSTR[31].
REQ-027 Legal opcodes SHALL be 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111 and 1110011; any other opcode SHALL be illegal.
REQ-028 WE SHALL be 1 only for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP; illegal instructions SHALL issue with WE=0 and IMM=0.
REQ-029 ILL_CNT SHALL increment on each illegal issue and saturate at 255.

Reset
REQ-030 While RST=0, state SHALL be IDLE, pending SHALL be 0, hold register SHALL be 0, and all outputs SHALL be 0 except IN_READY=1.
REQ-031 Assertion of RST during HOLD SHALL discard the held instruction without issuing it.

Configuration
REQ-032 Macro DECODE_SCOREBOARD_EN defined: the scoreboard and HOLD SHALL behave as specified above.
REQ-033 Macro DECODE_SCOREBOARD_EN undefined: there SHALL be no pending bitmap, no hazard is ever detected, the state SHALL remain IDLE, IN_READY SHALL be constant 1, and WB_DONE and WB_RD SHALL be ignored.

Verification
REQ-034 SHALL cover: INSTR=0x00700293 (addi x5,x0,7), IN_VALID=1 -> next edge: OUT_VALID=1, A1=0, A3=5, WE=1, IMM=0x00000007, pending[5]=1.
REQ-035 SHALL cover: INSTR=0xFE20AE23 (sw x2,-4(x1)) -> A1=1, A2=2, WE=0, IMM=0xFFFFFFFC.
REQ-036 SHALL cover: after REQ-034, INSTR=0x00528333 (add x6,x5,x5) -> IN_READY=0, OUT_VALID=0 for 3 cycles; then WB_DONE=1 with WB_RD=5 -> issue on that edge with A3=6.
REQ-037 SHALL cover: INSTR=0x00000000 issued 300 times -> ILLEGAL=1 and WE=0 each time, ILL_CNT=255.
REQ-038 SHALL cover: RST pulsed low while in HOLD -> IN_READY=1, OUT_VALID=0, pending all 0, held instruction never issued.
REQ-039 SHALL cover: DECODE_SCOREBOARD_EN undefined, REQ-034 then REQ-036 instruction back-to-back -> two consecutive OUT_VALID pulses.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register-hazard scoreboard and an IDLE/HOLD stall FSM.
// Latency: one CLK_DC edge from accept (or from the hazard clearing while in HOLD) to OUT_VALID.
// Backpressure: IN_READY drops while a hazarded word sits in HOLD; INSTR is ignored until it issues.
//
// Ports:
//   RST (async, active-low), CLK_DC
//   INSTR[31:0], IN_VALID, IN_READY      - instruction input handshake
//   WB_DONE, WB_RD[4:0]                  - writeback retire, clears the pending bit of WB_RD
//   A1/A2/A3[4:0], WE, IMM[31:0]         - register-file addresses, write enable, immediate
//   OPCODE[6:0], FUNCT3[2:0], FUNCT7B5   - pass-through fields
//   OUT_VALID, ILLEGAL, ILL_CNT[7:0]     - issue pulse, unrecognised opcode, saturating illegal count
//
// Build option: DECODE_SCOREBOARD_EN enables the pending bitmap and the HOLD state. Without it,
// no hazard is ever seen, IN_READY is constant 1 and WB_DONE/WB_RD are unused.
module decode_stage (
  input  logic        RST,
  input  logic        CLK_DC,
  input  logic [31:0] INSTR,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        WB_DONE,
  input  logic [4:0]  WB_RD,
  output logic [4:0]  A1,
  output logic [4:0]  A2,
  output logic [4:0]  A3,
  output logic        WE,
  output logic [31:0] IMM,
  output logic [6:0]  OPCODE,
  output logic [2:0]  FUNCT3,
  output logic        FUNCT7B5,
  output logic        OUT_VALID,
  output logic        ILLEGAL,
  output logic [7:0]  ILL_CNT
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // FMT_X marks an unrecognised opcode.
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

  logic [31:0] cur_word;   // word being decoded: live INSTR in IDLE, held word in HOLD
  logic        issue;
  fmt_e        fmt;
  logic        we_dec;
  logic        illegal_dec;
  logic [31:0] imm_dec;

  // Field decode of the current word.
  always_comb begin
    fmt    = FMT_X;
    we_dec = 1'b0;
    case (cur_word[6:0])
      OP_LUI:    begin fmt = FMT_U; we_dec = 1'b1; end
      OP_AUIPC:  begin fmt = FMT_U; we_dec = 1'b1; end
      OP_JAL:    begin fmt = FMT_J; we_dec = 1'b1; end
      OP_JALR:   begin fmt = FMT_I; we_dec = 1'b1; end
      OP_BRANCH: begin fmt = FMT_B; end
      OP_LOAD:   begin fmt = FMT_I; we_dec = 1'b1; end
      OP_STORE:  begin fmt = FMT_S; end
      OP_IMM:    begin fmt = FMT_I; we_dec = 1'b1; end
      OP_OP:     begin fmt = FMT_R; we_dec = 1'b1; end
      // FENCE and SYSTEM carry an I-type layout (rs1 + 12-bit immediate) but never write rd.
      OP_FENCE:  begin fmt = FMT_I; end
      OP_SYSTEM: begin fmt = FMT_I; end
      default:   begin fmt = FMT_X; end
    endcase
  end

  assign illegal_dec = (fmt == FMT_X);

  // R format has no immediate; it and illegal words issue IMM=0.
  always_comb begin
    imm_dec = 32'h0;
    case (fmt)
      FMT_I:   imm_dec = {{20{cur_word[31]}}, cur_word[31:20]};
      FMT_S:   imm_dec = {{20{cur_word[31]}}, cur_word[31:25], cur_word[11:7]};
      FMT_B:   imm_dec = {{19{cur_word[31]}}, cur_word[31], cur_word[7], cur_word[30:25],
                          cur_word[11:8], 1'b0};
      FMT_U:   imm_dec = {cur_word[31:12], 12'h0};
      FMT_J:   imm_dec = {{11{cur_word[31]}}, cur_word[31], cur_word[19:12], cur_word[20],
                          cur_word[30:21], 1'b0};
      default: imm_dec = 32'h0;
    endcase
  end

`ifdef DECODE_SCOREBOARD_EN
  typedef enum logic {IDLE, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] hold_q;
  logic [31:0] pending_q, pending_d;
  logic [31:0] wb_clr, rd_set, pend_eff;
  logic        use_rs1, use_rs2;
  logic        hazard;
  logic        capture;

  assign cur_word = (state_q == HOLD) ? hold_q : INSTR;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (fmt)
      FMT_R, FMT_S, FMT_B: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      FMT_I:               begin use_rs1 = 1'b1; end
      default:             begin use_rs1 = 1'b0; use_rs2 = 1'b0; end
    endcase
  end

  // A writeback retiring this cycle is bypassed into the hazard check; x0 never stalls.
  always_comb begin
    wb_clr = 32'h0;
    if (WB_DONE) wb_clr[WB_RD] = 1'b1;
    pend_eff    = pending_q & ~wb_clr;
    pend_eff[0] = 1'b0;
  end

  assign hazard = (use_rs1 && pend_eff[cur_word[19:15]]) ||
                  (use_rs2 && pend_eff[cur_word[24:20]]);

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    capture  = 1'b0;
    IN_READY = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          if (hazard) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            issue = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!hazard) begin
          issue   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set is OR-ed in after the clear so a simultaneous set/clear of one register leaves it set.
  always_comb begin
    rd_set = 32'h0;
    if (issue && we_dec && (cur_word[11:7] != 5'd0)) rd_set[cur_word[11:7]] = 1'b1;
    pending_d = (pending_q & ~wb_clr) | rd_set;
  end

  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      hold_q    <= 32'h0;
      pending_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (capture) hold_q <= INSTR;
    end
  end
`else
  logic unused_wb;

  assign cur_word  = INSTR;
  assign IN_READY  = 1'b1;
  assign issue     = IN_VALID;
  assign unused_wb = ^{WB_DONE, WB_RD};
`endif

  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      A1        <= 5'd0;
      A2        <= 5'd0;
      A3        <= 5'd0;
      WE        <= 1'b0;
      IMM       <= 32'h0;
      OPCODE    <= 7'd0;
      FUNCT3    <= 3'd0;
      FUNCT7B5  <= 1'b0;
      OUT_VALID <= 1'b0;
      ILLEGAL   <= 1'b0;
      ILL_CNT   <= 8'd0;
    end else begin
      OUT_VALID <= issue;
      if (issue) begin
        A1       <= cur_word[19:15];
        A2       <= cur_word[24:20];
        A3       <= cur_word[11:7];
        WE       <= we_dec;
        IMM      <= imm_dec;
        OPCODE   <= cur_word[6:0];
        FUNCT3   <= cur_word[14:12];
        FUNCT7B5 <= cur_word[30];
        ILLEGAL  <= illegal_dec;
        if (illegal_dec && (ILL_CNT != 8'hFF)) ILL_CNT <= ILL_CNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic        we;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic        illegal;
  } exp_t;

  logic        RST;
  logic        CLK_DC;
  logic [31:0] INSTR;
  logic        IN_VALID;
  logic        IN_READY;
  logic        WB_DONE;
  logic [4:0]  WB_RD;
  logic [4:0]  A1, A2, A3;
  logic        WE;
  logic [31:0] IMM;
  logic [6:0]  OPCODE;
  logic [2:0]  FUNCT3;
  logic        FUNCT7B5;
  logic        OUT_VALID;
  logic        ILLEGAL;
  logic [7:0]  ILL_CNT;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  decode_stage dut (
    .RST(RST), .CLK_DC(CLK_DC), .INSTR(INSTR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .WB_DONE(WB_DONE), .WB_RD(WB_RD), .A1(A1), .A2(A2), .A3(A3), .WE(WE), .IMM(IMM),
    .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7B5(FUNCT7B5), .OUT_VALID(OUT_VALID),
    .ILLEGAL(ILLEGAL), .ILL_CNT(ILL_CNT)
  );

  initial CLK_DC = 1'b0;
  always #5 CLK_DC = ~CLK_DC;

  function automatic exp_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                              input logic we, input logic [31:0] imm, input logic [6:0] op,
                              input logic [2:0] f3, input logic f7, input logic ill);
    exp_t e;
    e = '{a1: a1, a2: a2, a3: a3, we: we, imm: imm, opcode: op, funct3: f3, f7b5: f7, illegal: ill};
    return e;
  endfunction

  // Hand-decoded expectations for each instruction word used below.
  localparam logic [31:0] I_ADDI5 = 32'h00700293; // addi x5,x0,7
  localparam logic [31:0] I_ADDI6 = 32'h00500313; // addi x6,x0,5 (rs2 field = 5)
  localparam logic [31:0] I_SW    = 32'hFE20AE23; // sw x2,-4(x1)
  localparam logic [31:0] I_ADD   = 32'h00528333; // add x6,x5,x5
  localparam logic [31:0] I_ADDI7 = 32'h00130393; // addi x7,x6,1
  localparam logic [31:0] I_LUI   = 32'h123453B7; // lui x7,0x12345
  localparam logic [31:0] I_JAL   = 32'hFF9FF0EF; // jal x1,-8
  localparam logic [31:0] I_BEQ   = 32'h00208863; // beq x1,x2,16

  exp_t E_ADDI5, E_ADDI6, E_SW, E_ADD, E_ADDI7, E_LUI, E_JAL, E_BEQ, E_ILL;

  initial begin
    E_ADDI5 = mk(5'd0,  5'd7,  5'd5,  1'b1, 32'h00000007, 7'h13, 3'd0, 1'b0, 1'b0);
    E_ADDI6 = mk(5'd0,  5'd5,  5'd6,  1'b1, 32'h00000005, 7'h13, 3'd0, 1'b0, 1'b0);
    E_SW    = mk(5'd1,  5'd2,  5'd28, 1'b0, 32'hFFFFFFFC, 7'h23, 3'd2, 1'b1, 1'b0);
    E_ADD   = mk(5'd5,  5'd5,  5'd6,  1'b1, 32'h00000000, 7'h33, 3'd0, 1'b0, 1'b0);
    E_ADDI7 = mk(5'd6,  5'd1,  5'd7,  1'b1, 32'h00000001, 7'h13, 3'd0, 1'b0, 1'b0);
    E_LUI   = mk(5'd8,  5'd3,  5'd7,  1'b1, 32'h12345000, 7'h37, 3'd5, 1'b0, 1'b0);
    E_JAL   = mk(5'd31, 5'd25, 5'd1,  1'b1, 32'hFFFFFFF8, 7'h6F, 3'd7, 1'b1, 1'b0);
    E_BEQ   = mk(5'd1,  5'd2,  5'd16, 1'b0, 32'h00000010, 7'h63, 3'd0, 1'b0, 1'b0);
    E_ILL   = mk(5'd0,  5'd0,  5'd0,  1'b0, 32'h00000000, 7'h00, 3'd0, 1'b0, 1'b1);
  end

  // Output monitor: every issue must match the oldest outstanding expectation.
  always @(negedge CLK_DC) begin
    exp_t e, o;
    if (RST === 1'b1 && OUT_VALID === 1'b1) begin
      n_checks++;
      o = '{a1: A1, a2: A2, a3: A3, we: WE, imm: IMM, opcode: OPCODE, funct3: FUNCT3,
            f7b5: FUNCT7B5, illegal: ILLEGAL};
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue: got %h, no issue expected", o);
      end else begin
        e = sb.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL issue_fields: got a1=%0d a2=%0d a3=%0d we=%b imm=%h op=%h f3=%0d f7b5=%b ill=%b, want a1=%0d a2=%0d a3=%0d we=%b imm=%h op=%h f3=%0d f7b5=%b ill=%b",
                   o.a1, o.a2, o.a3, o.we, o.imm, o.opcode, o.funct3, o.f7b5, o.illegal,
                   e.a1, e.a2, e.a3, e.we, e.imm, e.opcode, e.funct3, e.f7b5, e.illegal);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one word for one cycle and require it to issue without a stall.
  task automatic issue(input logic [31:0] instr, input exp_t e, input logic wb,
                       input logic [4:0] wbrd, input string name);
    @(negedge CLK_DC);
    INSTR = instr; IN_VALID = 1'b1; WB_DONE = wb; WB_RD = wbrd;
    sb.push_back(e);
    @(negedge CLK_DC);
    IN_VALID = 1'b0; WB_DONE = 1'b0;
    n_checks++;
    if (OUT_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_no_stall: OUT_VALID=%b, want 1", name, OUT_VALID);
    end
  endtask

  task automatic wb_pulse(input logic [4:0] rd);
    @(negedge CLK_DC);
    WB_DONE = 1'b1; WB_RD = rd;
    @(negedge CLK_DC);
    WB_DONE = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b0; INSTR = 32'h0; IN_VALID = 1'b0; WB_DONE = 1'b0; WB_RD = 5'd0;
    repeat (2) @(negedge CLK_DC);
    n_checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake: IN_READY=%b OUT_VALID=%b, want 1 0", IN_READY, OUT_VALID);
    end
    n_checks++;
    if ({A1, A2, A3, WE, IMM, OPCODE, FUNCT3, FUNCT7B5, ILLEGAL, ILL_CNT} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: a1=%0d a2=%0d a3=%0d we=%b imm=%h ill=%b cnt=%0d, want all 0",
                         A1, A2, A3, WE, IMM, ILLEGAL, ILL_CNT);
    end
`ifdef DECODE_SCOREBOARD_EN
    n_checks++;
    if (dut.pending_q !== 32'h0) begin
      n_fail++; $display("FAIL reset_pending: got %h, want 0", dut.pending_q);
    end
`endif
    RST = 1'b1;
  endtask

  task automatic test_addi;
    issue(I_ADDI5, E_ADDI5, 1'b0, 5'd0, "addi_x5");
`ifdef DECODE_SCOREBOARD_EN
    n_checks++;
    if (dut.pending_q[5] !== 1'b1) begin
      n_fail++; $display("FAIL addi_pending5: got %b, want 1", dut.pending_q[5]);
    end
`endif
  endtask

  // I format must not look at rs2 even when that field names a pending register.
  task automatic test_i_format;
    issue(I_ADDI6, E_ADDI6, 1'b0, 5'd0, "addi_rs2_ignored");
  endtask

  task automatic test_store;
    issue(I_SW, E_SW, 1'b0, 5'd0, "sw");
  endtask

`ifdef DECODE_SCOREBOARD_EN
  task automatic test_hazard;
    @(negedge CLK_DC);
    INSTR = I_ADD; IN_VALID = 1'b1;
    sb.push_back(E_ADD);
    @(negedge CLK_DC);
    // Keep offering a different word; it must be ignored while the add is held.
    INSTR = I_LUI;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: IN_READY=%b OUT_VALID=%b, want 0 0", c, IN_READY, OUT_VALID);
      end
      if (c < 2) @(negedge CLK_DC);
    end
    IN_VALID = 1'b0; WB_DONE = 1'b1; WB_RD = 5'd5;
    @(negedge CLK_DC);
    WB_DONE = 1'b0;
    n_checks++;
    if (OUT_VALID !== 1'b1 || IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: OUT_VALID=%b IN_READY=%b, want 1 1", OUT_VALID, IN_READY);
    end
    n_checks++;
    if (dut.pending_q[5] !== 1'b0 || dut.pending_q[6] !== 1'b1) begin
      n_fail++; $display("FAIL hold_pending: p5=%b p6=%b, want 0 1", dut.pending_q[5], dut.pending_q[6]);
    end
  endtask
`else
  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    @(negedge CLK_DC);
    INSTR = I_ADDI5; IN_VALID = 1'b1; sb.push_back(E_ADDI5);
    @(negedge CLK_DC);
    if (OUT_VALID === 1'b1) pulses++;
    INSTR = I_ADD; sb.push_back(E_ADD);
    @(negedge CLK_DC);
    if (OUT_VALID === 1'b1) pulses++;
    IN_VALID = 1'b0;
    n_checks++;
    if (pulses != 2 || IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL back_to_back: pulses=%0d IN_READY=%b, want 2 1", pulses, IN_READY);
    end
  endtask
`endif

  task automatic test_bypass;
    // x6 retires on the same edge that addi x7,x6,1 is offered: no stall.
    issue(I_ADDI7, E_ADDI7, 1'b1, 5'd6, "bypass_x6");
    // lui writes x7 on the same edge x7 retires: the bit must remain set.
    issue(I_LUI, E_LUI, 1'b1, 5'd7, "set_clear_x7");
`ifdef DECODE_SCOREBOARD_EN
    n_checks++;
    if (dut.pending_q !== 32'h0000_0080) begin
      n_fail++; $display("FAIL set_wins: pending=%h, want 00000080", dut.pending_q);
    end
`endif
    wb_pulse(5'd7);
`ifdef DECODE_SCOREBOARD_EN
    n_checks++;
    if (dut.pending_q !== 32'h0) begin
      n_fail++; $display("FAIL wb_clear: pending=%h, want 0", dut.pending_q);
    end
`endif
  endtask

  task automatic test_formats;
    issue(I_BEQ, E_BEQ, 1'b0, 5'd0, "beq");
    issue(I_JAL, E_JAL, 1'b0, 5'd0, "jal");
    wb_pulse(5'd1);
  endtask

  task automatic test_illegal;
    @(negedge CLK_DC);
    INSTR = 32'h0; IN_VALID = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sb.push_back(E_ILL);
      @(negedge CLK_DC);
      if (i == 0) begin
        n_checks++;
        if (ILL_CNT !== 8'd1) begin n_fail++; $display("FAIL ill_cnt_first: got %0d, want 1", ILL_CNT); end
      end
      if (i == 254) begin
        n_checks++;
        if (ILL_CNT !== 8'd255) begin n_fail++; $display("FAIL ill_cnt_255: got %0d, want 255", ILL_CNT); end
      end
    end
    IN_VALID = 1'b0;
    n_checks++;
    if (ILL_CNT !== 8'd255) begin n_fail++; $display("FAIL ill_cnt_saturate: got %0d, want 255", ILL_CNT); end
  endtask

  task automatic test_reset_in_hold;
    int pulses;
    issue(I_ADDI5, E_ADDI5, 1'b0, 5'd0, "addi_before_hold");
`ifdef DECODE_SCOREBOARD_EN
    @(negedge CLK_DC);
    INSTR = I_ADD; IN_VALID = 1'b1;
    @(negedge CLK_DC);
    IN_VALID = 1'b0;
    n_checks++;
    if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL enter_hold: IN_READY=%b, want 0", IN_READY); end
`endif
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || A3 !== 5'd0 || WE !== 1'b0 || ILL_CNT !== 8'd0) begin
      n_fail++; $display("FAIL reset_mid: IN_READY=%b OUT_VALID=%b a3=%0d we=%b cnt=%0d, want 1 0 0 0 0",
                         IN_READY, OUT_VALID, A3, WE, ILL_CNT);
    end
`ifdef DECODE_SCOREBOARD_EN
    n_checks++;
    if (dut.pending_q !== 32'h0 || dut.hold_q !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_state: pending=%h hold=%h, want 0 0", dut.pending_q, dut.hold_q);
    end
`endif
    @(negedge CLK_DC);
    RST = 1'b1;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK_DC);
      if (OUT_VALID === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL held_discarded: pulses=%0d IN_READY=%b, want 0 1", pulses, IN_READY);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_i_format();
    test_store();
`ifdef DECODE_SCOREBOARD_EN
    test_hazard();
`else
    test_back_to_back();
`endif
    test_bypass();
    test_formats();
    test_illegal();
    test_reset_in_hold();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge CLK_DC);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d issues outstanding, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
